// File: rtl/dds_multi_ch.sv
// Multi-channel DDS engine: SPI-written shadow registers, global commit, per-channel phase accumulator,
// sine/square/triangle/saw with amplitude scaling. Define DDS_PHASE_SYNC_EN to clear all accumulators on commit.
module dds_multi_ch #(
  parameter int NUM_CH   = 2,
  parameter int ACC_W    = 32,
  parameter int LUT_AW   = 8,
  parameter int OUT_W    = 14,
  parameter int FTW_MULT = 43
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_done,
  input  logic [7:0]               cmd,
  input  logic                     data_done,
  input  logic [31:0]              data,
  output logic [NUM_CH*LUT_AW-1:0] rom_addr,
  input  logic [NUM_CH*OUT_W-1:0]  rom_q,
  output logic [NUM_CH*OUT_W-1:0]  wave_out,
  output logic [NUM_CH-1:0]        ch_active,
  output logic                     cmd_err
);

  localparam logic [OUT_W-1:0] MID     = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [8:0]       AMP_MAX = 9'd256;

  logic [7:0]       cur_cmd_r;
  logic [ACC_W-1:0] ftw_sh_r  [NUM_CH];
  logic [ACC_W-1:0] ph_sh_r   [NUM_CH];
  logic [1:0]       mode_sh_r [NUM_CH];
  logic [8:0]       amp_sh_r  [NUM_CH];
  logic [NUM_CH-1:0] en_sh_r;
  logic [ACC_W-1:0] ftw_lv_r  [NUM_CH];
  logic [ACC_W-1:0] ph_lv_r   [NUM_CH];
  logic [1:0]       mode_lv_r [NUM_CH];
  logic [8:0]       amp_lv_r  [NUM_CH];
  logic [NUM_CH-1:0] en_lv_r;
  logic [ACC_W-1:0] acc_r     [NUM_CH];

  logic [NUM_CH*LUT_AW-1:0] rom_addr_r;
  logic [OUT_W-1:0] s1_r [NUM_CH];
  logic [1:0]       mode1_r [NUM_CH];
  logic [8:0]       amp1_r [NUM_CH];
  logic [NUM_CH-1:0] en1_r;
  logic [OUT_W-1:0] s2_r [NUM_CH];
  logic [1:0]       mode2_r [NUM_CH];
  logic [8:0]       amp2_r [NUM_CH];
  logic [NUM_CH-1:0] en2_r;
  logic [NUM_CH*OUT_W-1:0] wave_r;
  logic [NUM_CH-1:0] ch_active_r;
  logic             cmd_err_r;

  logic [3:0]       reg_id_s;
  logic [3:0]       ch_sel_s;
  logic             wr_s;
  logic             commit_s;
  logic             err_s;
  logic [ACC_W-1:0] ftw_raw_s;
  logic [ACC_W-1:0] ftw_hz_s;
  logic [8:0]       amp_wr_s;
  logic [OUT_W-1:0] top_s  [NUM_CH];
  logic [OUT_W-1:0] raw_s  [NUM_CH];
  logic signed [OUT_W:0]    diff_s [NUM_CH];
  logic signed [OUT_W+10:0] prod_s [NUM_CH];
  logic [OUT_W-1:0] wave_nx_s [NUM_CH];

  assign reg_id_s  = cur_cmd_r[7:4];
  assign ch_sel_s  = cur_cmd_r[3:0];
  assign ftw_raw_s = ACC_W'(data);
  assign ftw_hz_s  = ACC_W'(64'(data) * 64'(FTW_MULT));
  assign amp_wr_s  = (data > 32'd256) ? AMP_MAX : data[8:0];

  // Decode the data strobe against the latched command
  always_comb begin
    wr_s     = 1'b0;
    commit_s = 1'b0;
    err_s    = 1'b0;
    if (data_done) begin
      case (reg_id_s)
        4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
          if (int'(ch_sel_s) < NUM_CH) wr_s = 1'b1;
          else                         err_s = 1'b1;
        end
        4'd15:   commit_s = 1'b1;
        default: err_s = 1'b1;
      endcase
    end else begin
      wr_s     = 1'b0;
      commit_s = 1'b0;
      err_s    = 1'b0;
    end
  end

  // Command latch, shadow/live register file and phase accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_cmd_r <= 8'd0;
      cmd_err_r <= 1'b0;
      en_sh_r   <= '0;
      en_lv_r   <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        ftw_sh_r[n]  <= '0;
        ph_sh_r[n]   <= '0;
        mode_sh_r[n] <= 2'd0;
        amp_sh_r[n]  <= 9'd0;
        ftw_lv_r[n]  <= '0;
        ph_lv_r[n]   <= '0;
        mode_lv_r[n] <= 2'd0;
        amp_lv_r[n]  <= 9'd0;
        acc_r[n]     <= '0;
      end
    end else begin
      cmd_err_r <= err_s;
      // Data uses the command latched before this cycle, so a simultaneous cmd_done only affects later writes
      if (cmd_done) cur_cmd_r <= cmd;
      for (int n = 0; n < NUM_CH; n++) begin
        if (wr_s && (int'(ch_sel_s) == n)) begin
          case (reg_id_s)
            4'd0:    ftw_sh_r[n]  <= ftw_raw_s;
            4'd1:    ftw_sh_r[n]  <= ftw_hz_s;
            4'd2:    ph_sh_r[n]   <= ftw_raw_s;
            4'd3:    mode_sh_r[n] <= data[1:0];
            4'd4:    amp_sh_r[n]  <= amp_wr_s;
            4'd5:    en_sh_r[n]   <= data[0];
            default: ;
          endcase
        end
        if (commit_s) begin
          ftw_lv_r[n]  <= ftw_sh_r[n];
          ph_lv_r[n]   <= ph_sh_r[n];
          mode_lv_r[n] <= mode_sh_r[n];
          amp_lv_r[n]  <= amp_sh_r[n];
          en_lv_r[n]   <= en_sh_r[n];
        end
`ifdef DDS_PHASE_SYNC_EN
        if (commit_s)        acc_r[n] <= '0;
        else if (en_lv_r[n]) acc_r[n] <= acc_r[n] + ftw_lv_r[n];
`else
        if (en_lv_r[n])      acc_r[n] <= acc_r[n] + ftw_lv_r[n];
`endif
      end
    end
  end

  // Top bits of the offset phase feed both the ROM address and the computed waveforms
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      top_s[n] = OUT_W'((acc_r[n] + ph_lv_r[n]) >> (ACC_W - OUT_W));
    end
  end

  // Raw waveform select and signed amplitude scaling around mid-scale
  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      raw_s[n] = s2_r[n];
      case (mode2_r[n])
        2'd0:    raw_s[n] = rom_q[n*OUT_W +: OUT_W];
        2'd1:    raw_s[n] = s2_r[n][OUT_W-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
        2'd2:    raw_s[n] = s2_r[n][OUT_W-1] ? ~{s2_r[n][OUT_W-2:0], 1'b0} : {s2_r[n][OUT_W-2:0], 1'b0};
        2'd3:    raw_s[n] = s2_r[n];
        default: raw_s[n] = s2_r[n];
      endcase
      diff_s[n] = $signed({1'b0, raw_s[n]}) - $signed({1'b0, MID});
      prod_s[n] = (OUT_W+11)'(diff_s[n]) * (OUT_W+11)'($signed({1'b0, amp2_r[n]}));
      if (en2_r[n]) wave_nx_s[n] = OUT_W'(prod_s[n] >>> 8) + MID;
      else          wave_nx_s[n] = MID;
    end
  end

  // Three-stage output pipeline aligned with the external ROM read latency
  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr_r  <= '0;
      en1_r       <= '0;
      en2_r       <= '0;
      ch_active_r <= '0;
      wave_r      <= {NUM_CH{MID}};
      for (int n = 0; n < NUM_CH; n++) begin
        s1_r[n]    <= '0;
        mode1_r[n] <= 2'd0;
        amp1_r[n]  <= 9'd0;
        s2_r[n]    <= '0;
        mode2_r[n] <= 2'd0;
        amp2_r[n]  <= 9'd0;
      end
    end else begin
      ch_active_r <= en_lv_r;
      en1_r       <= en_lv_r;
      en2_r       <= en1_r;
      for (int n = 0; n < NUM_CH; n++) begin
        rom_addr_r[n*LUT_AW +: LUT_AW] <= top_s[n][OUT_W-1 -: LUT_AW];
        s1_r[n]    <= top_s[n];
        mode1_r[n] <= mode_lv_r[n];
        amp1_r[n]  <= amp_lv_r[n];
        s2_r[n]    <= s1_r[n];
        mode2_r[n] <= mode1_r[n];
        amp2_r[n]  <= amp1_r[n];
        wave_r[n*OUT_W +: OUT_W] <= wave_nx_s[n];
      end
    end
  end

  assign rom_addr  = rom_addr_r;
  assign wave_out  = wave_r;
  assign ch_active = ch_active_r;
  assign cmd_err   = cmd_err_r;

endmodule

// File: tb/tb_dds_multi_ch.sv
// Self-checking bench for dds_multi_ch: a cycle-level behavioural model predicts every output,
// and each scenario task compares DUT outputs against it plus directed spot values.
module tb_dds_multi_ch;
  localparam int NUM_CH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_done = 1'b0;
  logic [7:0]  cmd = 8'd0;
  logic        data_done = 1'b0;
  logic [31:0] data = 32'd0;
  logic [15:0] rom_addr;
  logic [27:0] rom_q = 28'd0;
  logic [27:0] wave_out;
  logic [1:0]  ch_active;
  logic        cmd_err;

  int n_pass = 0;
  int n_chk  = 0;

  dds_multi_ch dut (
    .clk(clk), .rst(rst), .cmd_done(cmd_done), .cmd(cmd), .data_done(data_done), .data(data),
    .rom_addr(rom_addr), .rom_q(rom_q), .wave_out(wave_out), .ch_active(ch_active), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] rom_fn(input logic [7:0] a);
    return 14'(int'(a) * 61 + 7);
  endfunction

  // external synchronous ROM, one read cycle
  always @(posedge clk) begin
    for (int n = 0; n < NUM_CH; n++) rom_q[n*14 +: 14] <= rom_fn(rom_addr[n*8 +: 8]);
  end

  // ---------------- behavioural model ----------------
  logic [31:0] m_ftw_sh [NUM_CH], m_ph_sh [NUM_CH], m_ftw_lv [NUM_CH], m_ph_lv [NUM_CH], m_acc [NUM_CH];
  int          m_mode_sh [NUM_CH], m_amp_sh [NUM_CH], m_en_sh [NUM_CH];
  int          m_mode_lv [NUM_CH], m_amp_lv [NUM_CH], m_en_lv [NUM_CH];
  logic [7:0]  m_cur;
  logic [27:0] exp_q [$];
  logic [27:0] exp_wave;
  logic [15:0] exp_addr;
  logic [1:0]  exp_act;
  logic        exp_err;

  function automatic int model_sample(input int c);
    logic [31:0] p;
    int s, r, d;
    p = m_acc[c] + m_ph_lv[c];
    s = int'(p >> 18);
    case (m_mode_lv[c])
      0:       r = int'(rom_fn(p[31:24]));
      1:       r = (s >= 8192) ? 16383 : 0;
      2:       r = (s < 8192) ? 2 * s : 32767 - 2 * s;
      default: r = s;
    endcase
    d = r - 8192;
    if (m_en_lv[c] == 0) return 8192;
    return 8192 + ((d * m_amp_lv[c]) >>> 8);
  endfunction

  task automatic model_edge();
    logic [27:0] cur_w;
    int id, ch;
    bit commit;
    if (rst) begin
      for (int n = 0; n < NUM_CH; n++) begin
        m_ftw_sh[n] = 32'd0; m_ph_sh[n] = 32'd0; m_ftw_lv[n] = 32'd0; m_ph_lv[n] = 32'd0; m_acc[n] = 32'd0;
        m_mode_sh[n] = 0; m_amp_sh[n] = 0; m_en_sh[n] = 0;
        m_mode_lv[n] = 0; m_amp_lv[n] = 0; m_en_lv[n] = 0;
      end
      m_cur = 8'd0;
      exp_q.delete();
      exp_q.push_back({2{14'd8192}});
      exp_q.push_back({2{14'd8192}});
      exp_wave = {2{14'd8192}};
      exp_addr = 16'd0;
      exp_act  = 2'd0;
      exp_err  = 1'b0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        cur_w[n*14 +: 14]  = 14'(model_sample(n));
        exp_addr[n*8 +: 8] = 8'((m_acc[n] + m_ph_lv[n]) >> 24);
        exp_act[n]         = (m_en_lv[n] != 0);
      end
      exp_q.push_back(cur_w);
      exp_wave = exp_q.pop_front();
      id = int'(m_cur[7:4]);
      ch = int'(m_cur[3:0]);
      exp_err = 1'b0;
      commit  = 1'b0;
      if (data_done) begin
        if (id == 15) commit = 1'b1;
        else if (id <= 5 && ch < NUM_CH) begin
          case (id)
            0: m_ftw_sh[ch] = data;
            1: m_ftw_sh[ch] = data * 32'd43;
            2: m_ph_sh[ch]  = data;
            3: m_mode_sh[ch] = int'(data & 32'd3);
            4: m_amp_sh[ch] = (data > 32'd256) ? 256 : int'(data);
            default: m_en_sh[ch] = int'(data & 32'd1);
          endcase
        end else exp_err = 1'b1;
      end
      for (int n = 0; n < NUM_CH; n++) begin
`ifdef DDS_PHASE_SYNC_EN
        if (commit) m_acc[n] = 32'd0;
        else if (m_en_lv[n] != 0) m_acc[n] = m_acc[n] + m_ftw_lv[n];
`else
        if (m_en_lv[n] != 0) m_acc[n] = m_acc[n] + m_ftw_lv[n];
`endif
        if (commit) begin
          m_ftw_lv[n] = m_ftw_sh[n]; m_ph_lv[n] = m_ph_sh[n];
          m_mode_lv[n] = m_mode_sh[n]; m_amp_lv[n] = m_amp_sh[n]; m_en_lv[n] = m_en_sh[n];
        end
      end
      if (cmd_done) m_cur = cmd;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] c);
    cmd_done = 1'b1; cmd = c;
    tick();
    cmd_done = 1'b0;
  endtask

  task automatic send_data(input logic [31:0] d);
    data_done = 1'b1; data = d;
    tick();
    data_done = 1'b0;
  endtask

  task automatic wr(input logic [7:0] c, input logic [31:0] d);
    send_cmd(c);
    send_data(d);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_chk++; if (wave_out !== {2{14'd8192}}) $display("FAIL reset_wave: got %h want %h", wave_out, {2{14'd8192}}); else n_pass++;
    n_chk++; if (ch_active !== 2'b00) $display("FAIL reset_active: got %b want 00", ch_active); else n_pass++;
    n_chk++; if (rom_addr !== 16'd0) $display("FAIL reset_addr: got %h want 0000", rom_addr); else n_pass++;
    n_chk++; if (cmd_err !== 1'b0) $display("FAIL reset_err: got %b want 0", cmd_err); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (wave_out !== {2{14'd8192}} || ch_active !== 2'b00)
        $display("FAIL reset_idle cyc %0d: got %h/%b want %h/00", i, wave_out, ch_active, {2{14'd8192}});
      else n_pass++;
    end
  endtask

  task automatic test_saw();
    logic [13:0] prev, step;
    wr(8'h10, 32'd1_000_000);
    wr(8'h30, 32'd3);
    wr(8'h40, 32'd256);
    wr(8'h50, 32'd1);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    prev = wave_out[13:0];
    for (int i = 0; i < 30; i++) begin
      tick();
      n_chk++;
      if ({wave_out, rom_addr, ch_active, cmd_err} !== {exp_wave, exp_addr, exp_act, exp_err})
        $display("FAIL saw_model cyc %0d: got %h want %h", i, {wave_out, rom_addr, ch_active, cmd_err}, {exp_wave, exp_addr, exp_act, exp_err});
      else n_pass++;
      step = 14'(wave_out[13:0] - prev);
      n_chk++;
      if (!(step == 14'd164 || step == 14'd165) || wave_out[27:14] !== 14'd8192)
        $display("FAIL saw_step cyc %0d: got step %0d ch1 %0d want 164/165 and 8192", i, step, wave_out[27:14]);
      else n_pass++;
      prev = wave_out[13:0];
    end
  endtask

  task automatic test_square_amp();
    logic [13:0] prev;
    wr(8'h00, 32'h8000_0000);
    wr(8'h30, 32'd1);
    wr(8'h40, 32'd128);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    prev = wave_out[13:0];
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (!(wave_out[13:0] == 14'd4096 || wave_out[13:0] == 14'd12287) || wave_out[13:0] == prev || wave_out !== exp_wave)
        $display("FAIL square_amp128 cyc %0d: got %0d (prev %0d) want alternating 4096/12287, model %h", i, wave_out[13:0], prev, exp_wave);
      else n_pass++;
      prev = wave_out[13:0];
    end
    wr(8'h40, 32'd0);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_chk++;
      if (wave_out[13:0] !== 14'd8192) $display("FAIL square_amp0 cyc %0d: got %0d want 8192", i, wave_out[13:0]);
      else n_pass++;
    end
    wr(8'h40, 32'd400);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    prev = wave_out[13:0];
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if (!(wave_out[13:0] == 14'd0 || wave_out[13:0] == 14'd16383) || wave_out[13:0] == prev)
        $display("FAIL square_amp400 cyc %0d: got %0d (prev %0d) want alternating 0/16383", i, wave_out[13:0], prev);
      else n_pass++;
      prev = wave_out[13:0];
    end
  endtask

  task automatic test_illegal();
    logic [7:0] bad [3];
    bad[0] = 8'h03; bad[1] = 8'h95; bad[2] = 8'h12;
    for (int k = 0; k < 3; k++) begin
      send_cmd(bad[k]);
      send_data($urandom);
      n_chk++;
      if (cmd_err !== 1'b1) $display("FAIL illegal_pulse cmd %h: got %b want 1", bad[k], cmd_err); else n_pass++;
      tick();
      n_chk++;
      if (cmd_err !== 1'b0) $display("FAIL illegal_clear cmd %h: got %b want 0", bad[k], cmd_err); else n_pass++;
    end
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_chk++;
      if ({wave_out, rom_addr, ch_active, cmd_err} !== {exp_wave, exp_addr, exp_act, exp_err})
        $display("FAIL illegal_nochange cyc %0d: got %h want %h", i, {wave_out, rom_addr, ch_active, cmd_err}, {exp_wave, exp_addr, exp_act, exp_err});
      else n_pass++;
    end
  endtask

  task automatic test_phase_offset();
    logic [31:0] f;
    logic [13:0] d;
    rst = 1'b1; tick(); rst = 1'b0;
    f = $urandom;
    for (int c = 0; c < NUM_CH; c++) begin
      wr({4'd0, 4'(c)}, f);
      wr({4'd3, 4'(c)}, 32'd3);
      wr({4'd4, 4'(c)}, 32'd256);
      wr({4'd5, 4'(c)}, 32'd1);
    end
    wr(8'h21, 32'h8000_0000);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    for (int i = 0; i < 12; i++) begin
      tick();
      d = 14'(wave_out[27:14] - wave_out[13:0]);
      n_chk++;
      if (d !== 14'd8192 || wave_out !== exp_wave)
        $display("FAIL phase_offset cyc %0d: got diff %0d wave %h want diff 8192 wave %h", i, d, wave_out, exp_wave);
      else n_pass++;
    end
    wr(8'h00, f ^ 32'h0123_4567);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      n_chk++;
      if ({wave_out, rom_addr, ch_active} !== {exp_wave, exp_addr, exp_act})
        $display("FAIL phase_recommit cyc %0d: got %h want %h", i, {wave_out, rom_addr, ch_active}, {exp_wave, exp_addr, exp_act});
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    send_cmd(8'h20);
    cmd_done = 1'b1; cmd = 8'h21; data_done = 1'b1; data = $urandom;
    tick();
    cmd_done = 1'b0; data_done = 1'b0;
    send_data($urandom);
    wr(8'hF0, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if ({wave_out, rom_addr, ch_active, cmd_err} !== {exp_wave, exp_addr, exp_act, exp_err})
        $display("FAIL back_to_back cyc %0d: got %h want %h", i, {wave_out, rom_addr, ch_active, cmd_err}, {exp_wave, exp_addr, exp_act, exp_err});
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int sel;
    logic [3:0] id4;
    for (int i = 0; i < 600; i++) begin
      sel = int'($urandom % 10);
      id4 = (sel < 6) ? 4'(sel) : ((sel < 8) ? 4'd15 : 4'($urandom % 16));
      cmd_done  = ($urandom % 4 == 0);
      cmd       = {id4, 4'($urandom % 3)};
      data_done = ($urandom % 3 == 0);
      data      = ($urandom % 2 == 0) ? $urandom_range(0, 511) : $urandom;
      rst       = ($urandom % 150 == 0);
      tick();
      n_chk++;
      if ({wave_out, rom_addr, ch_active, cmd_err} !== {exp_wave, exp_addr, exp_act, exp_err})
        $display("FAIL random cyc %0d: got %h want %h", i, {wave_out, rom_addr, ch_active, cmd_err}, {exp_wave, exp_addr, exp_act, exp_err});
      else n_pass++;
    end
    cmd_done = 1'b0; data_done = 1'b0; rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_square_amp();
    test_illegal();
    test_phase_offset();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dds_multi_ch.md
# dds_multi_ch

Multi-channel DDS waveform engine driven by the SPI command/data receiver. It replaces the single fixed-sine, frequency-only datapath behind the SPI interface. Each of NUM_CH channels has its own shadowed frequency word, phase offset, waveform mode, amplitude and enable, and all channels update together on a global commit. The block sits between the SPI receiver (cmd/data strobes) and the DAC pins, and drives an external synchronous sine ROM per channel.

## Interface
- NUM_CH, 2: number of channels (1..16)
- ACC_W, 32: phase accumulator width
- LUT_AW, 8: sine ROM address width
- OUT_W, 14: sample width, unsigned offset-binary
- FTW_MULT, 43: Hz-to-FTW multiplier (2^32 / 100 MHz)

- clk  in  1  sample clock, also the clock for all register writes
- rst  in  1  synchronous, active-high reset
- cmd_done  in  1  one-cycle strobe, cmd valid
- cmd  in  8  [7:4] register id, [3:0] channel
- data_done  in  1  one-cycle strobe, data valid
- data  in  32  write payload
- rom_addr  out  NUM_CH*LUT_AW  per-channel ROM address, channel n at [n*LUT_AW +: LUT_AW]
- rom_q  in  NUM_CH*OUT_W  ROM data, 1-cycle read latency
- wave_out  out  NUM_CH*OUT_W  per-channel sample
- ch_active  out  NUM_CH  live enable per channel
- cmd_err  out  1  one-cycle pulse on an illegal write

## Operation
- cmd_done latches cmd into cur_cmd. A data_done pulse writes data to the shadow register selected by cur_cmd.
- Register ids:
  - 0: FTW raw, truncated to ACC_W
  - 1: frequency in Hz; FTW = data*FTW_MULT, truncated to ACC_W
  - 2: phase offset (ACC_W bits)
  - 3: mode[1:0] (0 sine, 1 square, 2 triangle, 3 saw)
  - 4: amplitude[8:0]; values above 256 are clamped to 256 at write
  - 5: enable[0]
  - 15: commit. Applies to all channels; channel field and data are ignored; the commit happens on the data_done.
- Channel ≥ NUM_CH or ids 6–14: no write, cmd_err pulses.
- Commit copies every shadow register to its live register in the same cycle.
- Per channel, every cycle while enabled: acc ← acc + ftw_live. A disabled channel holds acc, and its wave_out is 2^(OUT_W-1).
- Phase p = acc + phase_live.
  - ROM address = p[ACC_W-1 -: LUT_AW].
  - Top sample bits s = p[ACC_W-1 -: OUT_W].
- Raw waveform r by mode:
  - Sine: rom_q.
  - Square: s[OUT_W-1] ? all-ones : 0.
  - Saw: s.
  - Triangle: s[OUT_W-1] ? ~{s[OUT_W-2:0],0} : {s[OUT_W-2:0],0}.
- Amplitude: out = M + (((r − M) * amp) >>> 8), with M = 2^(OUT_W-1). Use signed arithmetic with floor shift. amp = 256 gives r unchanged; amp = 0 gives M.

## Timing
- Reset values:
  - Shadow and live registers: all zero.
  - acc = 0, cur_cmd = 0.
  - wave_out = M on every channel.
  - rom_addr = 0, ch_active = 0, cmd_err = 0.
- Reset mid-operation aborts any pending write. wave_out shows M on the first cycle after rst.
- Latency: acc value at cycle t → rom_addr registered at t+1 → rom_q at t+2 → wave_out registered at t+3. Non-sine modes are delayed to the same latency.
- A live-register change via commit at cycle t is first visible on wave_out at t+3. ch_active follows the live enable at t+1.
- cmd_done and data_done in the same cycle: data is written using the old cur_cmd, then cmd is latched.
- Multiple data_done pulses after one cmd_done each rewrite the same register.
- Accumulator wraps modulo 2^ACC_W with no status flag.
- cmd_err is registered: it pulses the cycle after the offending data_done.

## Configuration
- DDS_PHASE_SYNC_EN defined: commit also clears acc of every channel in the same cycle, so all channels restart phase-aligned at their phase offsets.
- Not defined: commit changes only the live registers, and accumulators continue without a discontinuity.

## Test plan
- Reset, then no writes → all wave_out = 8192, ch_active = 0, rom_addr = 0.
- Ch0: write Hz=1_000_000 (FTW 43_000_000), mode 3, amp 256, enable 1, commit → ch0 acc increments by 43_000_000 per cycle; wave_out[0] = acc[31:18] three cycles later; ch1 stays at 8192.
- Ch0 square with amp 128 → wave_out alternates 4096 / 12287. Amp 0 → constant 8192. Amp write of 400 → behaves as 256 (16383 / 0).
- Write to channel 3 with NUM_CH=2, and a write with id 9 → cmd_err pulses once each; no registers change.
- Ch0 and ch1 with identical FTW, ch1 phase 0x8000_0000 in saw mode:
  - With DDS_PHASE_SYNC_EN: after commit, ch1 differs from ch0 by exactly 8192 mod 16384.
  - Without DDS_PHASE_SYNC_EN: accumulators continue from their prior values.
- cmd_done and data_done asserted together → data lands in the previously latched register; a subsequent data_done targets the new cmd.
